// File: rtl/mem_addr_seq_pkg.sv
// Shared types and default constants for the memory address sequencer.
package mem_addr_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  localparam int VEC_BASE_DEF = 253;
  localparam int MEM_TOP_DEF  = 255;

endpackage

// File: rtl/mem_addr_seq_wait_cnt.sv
// Per-beat hold counter. tick is registered and is high on the last cycle of a beat.
module mem_addr_seq_wait_cnt #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // enable&clear starts a beat at count 0; enable alone advances; !enable parks at 0.
  always_comb begin
    cnt_d = '0;
    if (enable && !clear) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= enable && (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/mem_addr_seq.sv
// Burst address sequencer: picks a register or vector base and walks consecutive addresses.
// Optional request bound check enabled by defining MEM_ADDR_SEQ_BOUND_CHECK_EN.
module mem_addr_seq
  import mem_addr_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_SRC       = 4,
  parameter int VEC_BASE    = VEC_BASE_DEF,
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_BURST   = 4,
  parameter int MEM_TOP     = MEM_TOP_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_SRC*DATA_W-1:0]        src_addr,
  input  logic [$clog2(N_SRC+1)-1:0]     sel,
  input  logic [$clog2(MAX_BURST+1)-1:0] burst_len,
  input  logic                           wr_in,
  input  logic                           req,
  input  logic                           abort,
  output logic                           ready,
  output logic                           busy,
  output logic [DATA_W-1:0]              mem_addr,
  output logic                           mem_wr,
  output logic                           beat_valid,
  output logic                           done,
  output logic                           err
);

  localparam int SEL_W = $clog2(N_SRC + 1);
  localparam int LEN_W = $clog2(MAX_BURST + 1);

  state_e            state_q;
  logic [DATA_W-1:0] base_q, mem_addr_q, sel_base;
  logic [LEN_W-1:0]  len_q, beat_q, len_sel, beat_nxt;
  logic              wr_q, mem_wr_q, done_q, err_q, busy_q;
  logic              tick, last_beat, bound_fail, accept, issue_go, wc_en, wc_clr;

  always_comb begin
    sel_base = DATA_W'(VEC_BASE);
    for (int i = 0; i < N_SRC; i++)
      if (sel == SEL_W'(i)) sel_base = src_addr[i*DATA_W +: DATA_W];
  end

  always_comb begin
    if (burst_len == '0)                     len_sel = LEN_W'(1);
    else if (burst_len > LEN_W'(MAX_BURST))  len_sel = LEN_W'(MAX_BURST);
    else                                     len_sel = burst_len;
  end

`ifdef MEM_ADDR_SEQ_BOUND_CHECK_EN
  // One extra bit so a burst that wraps past 2^DATA_W reads as out of range.
  logic [DATA_W:0] last_addr;
  assign last_addr  = {1'b0, sel_base} + (DATA_W+1)'(len_sel) - (DATA_W+1)'(1);
  assign bound_fail = last_addr > (DATA_W+1)'(MEM_TOP);
`else
  assign bound_fail = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && req && !abort && !bound_fail;
  assign issue_go  = (state_q == ISSUE) && !abort;
  assign last_beat = beat_q == (len_q - LEN_W'(1));
  assign beat_nxt  = beat_q + LEN_W'(1);
  assign wc_en     = accept || (issue_go && !(tick && last_beat));
  assign wc_clr    = accept || (issue_go && tick && !last_beat);

  mem_addr_seq_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wc_clr),
    .enable  (wc_en),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wr_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_wr_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q  <= IDLE;
        mem_wr_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (req) begin
            if (bound_fail) begin
              err_q <= 1'b1;
            end else begin
              base_q     <= sel_base;
              len_q      <= len_sel;
              wr_q       <= wr_in;
              beat_q     <= '0;
              mem_addr_q <= sel_base;
              mem_wr_q   <= wr_in;
              busy_q     <= 1'b1;
              state_q    <= ISSUE;
            end
          end
          ISSUE: if (tick) begin
            if (last_beat) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              mem_wr_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              beat_q     <= beat_nxt;
              mem_addr_q <= base_q + DATA_W'(beat_nxt);
              mem_wr_q   <= wr_q;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready      = (state_q == IDLE);
  assign busy       = busy_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign beat_valid = tick;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Random + directed check of two sequencers (hold 1 and hold 0) against a cycle-index model.
module tb_mem_addr_seq;
  localparam int DW = 8, NS = 4, MB = 4;

  logic            clk = 1'b0, reset_n = 1'b0;
  logic [NS*DW-1:0] src_addr = '0;
  logic [2:0]      sel = '0, burst_len = '0;
  logic            wr_in = 1'b0, req = 1'b0, abort = 1'b0;
  logic            rdy[2], bsy[2], mwr[2], bv[2], dn[2], er[2];
  logic [DW-1:0]   ma[2];

  // Model: n = cycles since accept (0 = idle); beat k = (n-1)/per, hold pos = (n-1)%per.
  int             n[2], len_m[2];
  logic [DW-1:0]  base_m[2], held[2];
  bit             wr_m[2], err_m[2];
  int             nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  mem_addr_seq #(.DATA_W(DW), .N_SRC(NS), .VEC_BASE(253), .WAIT_CYCLES(1),
                 .MAX_BURST(MB), .MEM_TOP(255)) u0 (
    .clk(clk), .reset_n(reset_n), .src_addr(src_addr), .sel(sel), .burst_len(burst_len),
    .wr_in(wr_in), .req(req), .abort(abort), .ready(rdy[0]), .busy(bsy[0]),
    .mem_addr(ma[0]), .mem_wr(mwr[0]), .beat_valid(bv[0]), .done(dn[0]), .err(er[0]));

  mem_addr_seq #(.DATA_W(DW), .N_SRC(NS), .VEC_BASE(253), .WAIT_CYCLES(0),
                 .MAX_BURST(MB), .MEM_TOP(255)) u1 (
    .clk(clk), .reset_n(reset_n), .src_addr(src_addr), .sel(sel), .burst_len(burst_len),
    .wr_in(wr_in), .req(req), .abort(abort), .ready(rdy[1]), .busy(bsy[1]),
    .mem_addr(ma[1]), .mem_wr(mwr[1]), .beat_valid(bv[1]), .done(dn[1]), .err(er[1]));

  function automatic int per_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; held[i] = '0; err_m[i] = 0; len_m[i] = 1; base_m[i] = '0; wr_m[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int per = per_of(i);
      err_m[i] = 0;
      if (abort) n[i] = 0;
      else if (n[i] == 0) begin
        if (req) begin
          int b, l;
          bit bad = 0;
          if (int'(sel) < NS) b = int'(src_addr[int'(sel)*DW +: DW]); else b = 253;
          if (burst_len == 0) l = 1; else if (int'(burst_len) > MB) l = MB; else l = int'(burst_len);
`ifdef MEM_ADDR_SEQ_BOUND_CHECK_EN
          bad = (b + l - 1) > 255;
`endif
          if (bad) err_m[i] = 1;
          else begin
            n[i] = 1; base_m[i] = b[DW-1:0]; len_m[i] = l; wr_m[i] = wr_in;
          end
        end
      end else if (n[i] == len_m[i]*per + 1) n[i] = 0;
      else n[i]++;
      if (n[i] > 0 && n[i] <= len_m[i]*per) held[i] = base_m[i] + DW'((n[i]-1)/per);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      int per = per_of(i);
      bit act_b = (n[i] > 0) && (n[i] <= len_m[i]*per);
      bit dn_b  = (n[i] > 0) && !act_b;
      chk($sformatf("u%0d.ready", i), 32'(rdy[i]), 32'(n[i] == 0));
      chk($sformatf("u%0d.busy", i), 32'(bsy[i]), 32'(act_b));
      chk($sformatf("u%0d.mem_wr", i), 32'(mwr[i]), 32'(act_b && wr_m[i]));
      chk($sformatf("u%0d.beat_valid", i), 32'(bv[i]), 32'(act_b && ((n[i]-1) % per == per-1)));
      chk($sformatf("u%0d.done", i), 32'(dn[i]), 32'(dn_b));
      chk($sformatf("u%0d.err", i), 32'(er[i]), 32'(err_m[i]));
      chk($sformatf("u%0d.mem_addr", i), 32'(ma[i]), 32'(held[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step(); else model_reset();
    #1 compare();
  endtask

  task automatic idle(int k);
    req = 0; abort = 0;
    for (int j = 0; j < k; j++) cycle();
  endtask

  task automatic start(int s, int bl, bit w);
    sel = 3'(s); burst_len = 3'(bl); wr_in = w; req = 1;
    cycle();
    req = 0;
  endtask

  task automatic reset_mid();
    #2 reset_n = 0;
    model_reset();
    #1;
    chk("rst.async.addr", 32'(ma[0]), 32'h0);
    chk("rst.async.ready", 32'(rdy[0]), 32'h1);
    chk("rst.async.busy", 32'(bsy[0]), 32'h0);
    compare();
    cycle();
    reset_n = 1;
  endtask

  initial begin
    int vaddr[6];
    int vbv[6];
    int waddr[4];
    vaddr = '{253, 253, 254, 254, 255, 255};
    vbv   = '{0, 1, 0, 1, 0, 1};
    waddr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    model_reset();
    cycle(); cycle();
    chk("rst.ready", 32'(rdy[0]), 32'h1);
    chk("rst.addr", 32'(ma[1]), 32'h0);
    reset_n = 1;
    idle(2);

    // Vector fetch: hold 1, three beats from 253.
    start(4, 3, 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cycle();
      chk($sformatf("vec.addr%0d", k), 32'(ma[0]), 32'(vaddr[k]));
      chk($sformatf("vec.bv%0d", k), 32'(bv[0]), 32'(vbv[k]));
    end
    cycle(); chk("vec.done", 32'(dn[0]), 32'h1);
    cycle(); chk("vec.ready", 32'(rdy[0]), 32'h1);
    idle(2);

    // Single register source, zero-length clamps to one beat.
    src_addr = 32'h0040_0000;
    start(2, 0, 1);
    chk("one.addr", 32'(ma[1]), 32'h40);
    chk("one.wr", 32'(mwr[1]), 32'h1);
    chk("one.bv", 32'(bv[1]), 32'h1);
    cycle(); chk("one.done", 32'(dn[1]), 32'h1);
    idle(4);

    // Clamp to MAX_BURST and wrap past 0xFF.
    src_addr = 32'h0000_00FE;
    start(0, 7, 0);
`ifdef MEM_ADDR_SEQ_BOUND_CHECK_EN
    chk("wrap.err", 32'(er[1]), 32'h1);
    chk("wrap.ready", 32'(rdy[1]), 32'h1);
`else
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap.addr%0d", k), 32'(ma[1]), 32'(waddr[k]));
      cycle();
    end
    chk("wrap.done", 32'(dn[1]), 32'h1);
`endif
    idle(10);

    // Abort during second beat of hold-1 instance.
    src_addr = 32'h0000_1000;
    start(1, 4, 1);
    cycle(); cycle();
    chk("abt.addr_pre", 32'(ma[0]), 32'h11);
    abort = 1;
    cycle();
    abort = 0;
    chk("abt.ready", 32'(rdy[0]), 32'h1);
    chk("abt.wr", 32'(mwr[0]), 32'h0);
    chk("abt.addr", 32'(ma[0]), 32'h11);
    cycle(); chk("abt.nodone", 32'(dn[0]), 32'h0);

    // req and abort together in IDLE: nothing starts.
    req = 1; abort = 1;
    cycle();
    req = 0; abort = 0;
    chk("col.ready", 32'(rdy[0]), 32'h1);
    cycle(); chk("col.busy", 32'(bsy[0]), 32'h0);

`ifdef MEM_ADDR_SEQ_BOUND_CHECK_EN
    src_addr = 32'h0000_00FE;
    start(0, 3, 0);
    chk("bnd.err", 32'(er[0]), 32'h1);
    chk("bnd.ready", 32'(rdy[0]), 32'h1);
    cycle(); chk("bnd.nobv", 32'(bv[0]), 32'h0);
    start(4, 3, 0);
    chk("bnd.ok_busy", 32'(bsy[0]), 32'h1);
    idle(10);
`endif

    // Reset in the middle of a hold.
    start(4, 3, 1);
    cycle();
    reset_mid();
    start(4, 1, 0);
    chk("rst.new_busy", 32'(bsy[0]), 32'h1);
    chk("rst.new_addr", 32'(ma[0]), 32'd253);
    idle(6);

    for (int c = 0; c < 4000; c++) begin
      req       = ($urandom_range(0, 9) < 4);
      abort     = ($urandom_range(0, 29) == 0);
      sel       = 3'($urandom_range(0, 7));
      burst_len = 3'($urandom_range(0, 7));
      wr_in     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        src_addr = $urandom();
        if ($urandom_range(0, 1) == 0)
          src_addr[int'(sel[1:0])*DW +: DW] = 8'($urandom_range(248, 255));
      end
      if ($urandom_range(0, 499) == 0) reset_mid();
      cycle();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_addr_seq.md
# mem_addr_seq

Parametrised memory address sequencer for the multicycle datapath. It selects one of N_SRC register-sourced base addresses or a fixed vector base. It then registers that address and drives a burst of consecutive byte addresses to memory, holding each address for a configurable number of wait cycles. Control logic gets per-beat and completion handshakes, so byte-serial accesses run without extra control states, e.g. exception vector fetch at 253..255.

## Interface
- DATA_W, 32, address width
- N_SRC, 4, number of register address sources
- VEC_BASE, 253, vector base address, selected when sel >= N_SRC
- WAIT_CYCLES, 1, extra cycles each address is held (0 allowed)
- MAX_BURST, 4, maximum beats per request
- MEM_TOP, 255, highest legal address (used only with bound check)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- src_addr  in  N_SRC*DATA_W  packed sources; source i at [i*DATA_W +: DATA_W]
- sel  in  $clog2(N_SRC+1)  source select
- burst_len  in  $clog2(MAX_BURST+1)  beats requested
- wr_in  in  1  write request, latched with req
- req  in  1  start request, accepted only when ready=1
- abort  in  1  synchronous abort
- ready  out  1  idle, accepting requests
- busy  out  1  burst in progress
- mem_addr  out  DATA_W  registered memory address
- mem_wr  out  1  registered write enable
- beat_valid  out  1  last cycle of current beat
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejected-request pulse

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE**
  - ready=1.
  - On req & !abort, latch three values:
    - base = src_addr[sel], or VEC_BASE if sel >= N_SRC.
    - len = clamp(burst_len, 1, MAX_BURST); burst_len=0 is treated as 1.
    - wr = wr_in.
  - Then go to ISSUE with beat=0 and wait counter=0.
- **ISSUE**
  - mem_addr = base + beat, truncated to DATA_W; wraps mod 2^DATA_W.
  - mem_wr = wr. busy=1.
  - The wait counter counts 0..WAIT_CYCLES. At WAIT_CYCLES, beat_valid=1.
  - If beat == len-1, go to DONE. Otherwise increment beat, clear the counter and stay in ISSUE.
- **DONE**
  - done=1, mem_wr=0, busy=0. Go to IDLE.
  - mem_addr holds its last value.
- **abort**: from any state, go to IDLE next edge. mem_wr clears, no done, mem_addr holds.
- **abort & req together in IDLE**: abort wins; the request is dropped.
- **req outside IDLE**: ignored, with no queueing.
- **Reset values**: state=IDLE, mem_addr=0, mem_wr=0, beat_valid=0, done=0, err=0, busy=0, ready=1.
- **Reset asserted mid-burst**: outputs take reset values immediately (asynchronously).

## Timing
- req sampled at edge T. mem_addr=base valid from T+1.
- Beat k occupies cycles T+1+k(W+1) .. T+(k+1)(W+1), where W=WAIT_CYCLES.
- beat_valid is high on the last cycle of each beat.
- done is high at T+L(W+1)+1. ready returns at T+L(W+1)+2.
- Back-to-back requests: earliest next accept is the cycle ready=1.
- All outputs are registered except ready, which is decoded from the state.

## Configuration
- Macro: MEM_ADDR_SEQ_BOUND_CHECK_EN.
- **Defined**: in IDLE, a req whose last address base+len-1 exceeds MEM_TOP is rejected.
  - The check uses DATA_W+1-bit arithmetic, so wrap-around counts as out of range.
  - err pulses at T+1. No beats are issued. State stays IDLE and ready stays 1.
- **Undefined**: err is tied 0, no check is made and wrap-around is permitted.

## Structure
- Package mem_addr_seq_pkg holds:
  - the state enum (IDLE, ISSUE, DONE);
  - the default constants VEC_BASE_DEF=253 and MEM_TOP_DEF=255.
- One sub-module, mem_addr_seq_wait_cnt:
  - parametrised by WAIT_CYCLES;
  - inputs: clear, enable;
  - output: last-cycle flag `tick`.
- The top level holds the FSM, the source mux, the beat counter and the address adder.

## Test plan
- **Vector fetch**: WAIT=1, sel=N_SRC, burst_len=3, req at T.
  - mem_addr reads 253,253,254,254,255,255 over T+1..T+6.
  - beat_valid at T+2, T+4, T+6. done at T+7. ready at T+8.
- **Single register source**: WAIT=0, sel=2, src_addr[2]=0x40, burst_len=0, wr_in=1.
  - mem_addr=0x40 and mem_wr=1 at T+1, beat_valid at T+1, done at T+2.
- **Clamp and wrap**: DATA_W=8, base=0xFE, burst_len=7, MAX_BURST=4, macro undefined.
  - Addresses 0xFE, 0xFF, 0x00, 0x01, then done.
- **Abort and request collision**:
  - abort at the second beat: IDLE next cycle, mem_wr=0, no done.
  - req+abort in IDLE: nothing starts.
- **Bound check** (macro defined): base=254, burst_len=3.
  - err at T+1, no beat_valid, ready stays 1.
  - base=253, burst_len=3 proceeds normally.
- **Reset mid-burst**: reset_n low during the ISSUE wait.
  - All outputs at reset values immediately. After release, a new req works normally.
